// File: rtl/oisc8_pkg.sv
// oisc8_pkg: shared widths, idle bus codes and fetch FSM state encoding for
// the OISC8 core.
//   SAWIDTH/DAWIDTH : source / destination address widths
//   IWIDTH          : instruction word width {imm, dst, src}
//   DST_IDLE        : destination code no port decodes (also the HALT code)
//   SRC_NULL        : idle source address
//   e_fetch_state   : fetch FSM states
package oisc8_pkg;

  localparam int SAWIDTH = 8;
  localparam int DAWIDTH = 4;
  localparam int IWIDTH  = SAWIDTH + DAWIDTH + 1;

  localparam logic [DAWIDTH-1:0] DST_IDLE = 4'hF;
  localparam logic [SAWIDTH-1:0] SRC_NULL = '0;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_EXEC = 2'd1,
    S_HALT = 2'd2
  } e_fetch_state;

  // A word whose destination is the idle code halts the core.
  function automatic logic is_halt(input logic [IWIDTH-1:0] word);
    return word[SAWIDTH +: DAWIDTH] == DST_IDLE;
  endfunction

endpackage

// File: rtl/oisc8_pc.sv
// oisc8_pc: program counter register.
//   clk, rst  : clock, synchronous active-high reset (loads RESET_PC)
//   hold      : keep current value (highest priority after rst)
//   load      : load load_val (branch)
//   inc       : advance by one, wrapping modulo 2^PC_WIDTH
//   load_val  : branch destination
//   pc        : current program counter
module oisc8_pc #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hold,
  input  logic                load,
  input  logic                inc,
  input  logic [PC_WIDTH-1:0] load_val,
  output logic [PC_WIDTH-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (hold) begin
      pc <= pc;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/oisc8_fetch.sv
// oisc8_fetch: instruction fetch / present FSM for the OISC8 core.
// Fetches one 13-bit word per instruction from the ROM, presents it on the
// instruction bus for (at least) one cycle, then advances or branches.
//   clk, rst        : clock, synchronous active-high reset
//   rom_addr/rom_rd : ROM address (= pc) and read request (S_REQ only)
//   rom_rdata/valid : returned instruction word and its strobe
//   stall           : hold the presented instruction
//   br_take/target  : branch condition and destination, used when leaving S_EXEC
//   imm, instr_dst, instr_src, imm_en, instr_valid : instruction bus
//   pc              : address of the presented instruction
//   halted          : core stopped on a HALT word; only rst restarts it
module oisc8_fetch
  import oisc8_pkg::*;
#(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] rom_addr,
  output logic                rom_rd,
  input  logic [IWIDTH-1:0]   rom_rdata,
  input  logic                rom_valid,
  input  logic                stall,
  input  logic                br_take,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic                imm,
  output logic [DAWIDTH-1:0]  instr_dst,
  output logic [SAWIDTH-1:0]  instr_src,
  output logic                imm_en,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted
);

  e_fetch_state      state;
  logic [IWIDTH-1:0] ir;
  logic              in_exec;
  logic              advance;

  // Leaving S_EXEC normally: not stalled and not a HALT word.
  assign advance = (state == S_EXEC) && !stall && !is_halt(ir);

  oisc8_pc #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .hold     (!advance),
    .load     (advance && br_take),
    .inc      (advance && !br_take),
    .load_val (br_target),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (rom_valid) begin
            ir    <= rom_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // HALT wins over stall and branch; pc stays on the HALT word.
          if (is_halt(ir)) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!stall) begin
            state <= S_REQ;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

  // Bus outputs are gated by rst so a reset cancels a fetch or stall at once.
  assign in_exec     = (state == S_EXEC) && !rst;
  assign rom_rd      = (state == S_REQ) && !rst;
  assign rom_addr    = pc;
  assign instr_valid = in_exec;
  assign imm         = in_exec && ir[IWIDTH-1];
  assign imm_en      = in_exec && ir[IWIDTH-1];
  assign instr_dst   = in_exec ? ir[SAWIDTH +: DAWIDTH] : DST_IDLE;
  assign instr_src   = in_exec ? ir[SAWIDTH-1:0]        : SRC_NULL;

endmodule
